// File: rtl/lacc_data_responder.sv
// Memory-side responder for the lacc data channel: turns sequential read commands into
// raster memory addresses and returns the read data in order, one cycle after memory.
module lacc_data_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BUFFER_WIDTH    = 32,
  parameter int BUFFER_DEPTH    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [15:0]                     row_pitch_i,
  input  logic [$clog2(BUFFER_WIDTH)-1:0] buffer_width_i,
  input  logic [$clog2(BUFFER_DEPTH)-1:0] buffer_depth_i,
  input  logic                            lacc_data_valid,
  output logic                            lacc_data_ready,
  output logic                            lacc_drsp_valid,
  output logic [31:0]                     lacc_drsp_rdata,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  input  logic                            mem_rsp_valid,
  input  logic [31:0]                     mem_rsp_rdata,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int XW = $clog2(BUFFER_WIDTH);
  localparam int YW = $clog2(BUFFER_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [XW-1:0]         w_lat, x;
  logic [YW-1:0]         d_lat, y;
  logic [15:0]           pitch;
  logic [ADDR_WIDTH-1:0] addr, row_addr, pitch_ext;
  logic [OW-1:0]         outstanding;
  logic                  credit, issue, last_cmd, drain_done;

  assign pitch_ext       = ADDR_WIDTH'(pitch);
  assign credit          = outstanding < OW'(MAX_OUTSTANDING);
  assign lacc_data_ready = (state == RUN) & mem_req_ready & credit;
  assign mem_req_valid   = (state == RUN) & lacc_data_valid & credit;
  assign mem_req_addr    = addr;
  assign issue           = lacc_data_valid & lacc_data_ready;
  assign last_cmd        = (x == w_lat) & (y == d_lat);
  // Completion waits for the last word to leave the output register as well.
  assign drain_done      = (state == DRAIN) & (outstanding == '0) & ~lacc_drsp_valid;
  assign done            = drain_done;
  assign busy            = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && last_cmd) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      w_lat           <= '0;
      d_lat           <= '0;
      pitch           <= '0;
      x               <= '0;
      y               <= '0;
      addr            <= '0;
      row_addr        <= '0;
      outstanding     <= '0;
      lacc_drsp_valid <= 1'b0;
      lacc_drsp_rdata <= '0;
      err             <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && start) begin
        w_lat    <= buffer_width_i;
        d_lat    <= buffer_depth_i;
        pitch    <= row_pitch_i;
        x        <= '0;
        y        <= '0;
        addr     <= base_addr_i;
        row_addr <= base_addr_i;
        err      <= 1'b0;
      end else if (issue) begin
        if (x != w_lat) begin
          x    <= x + 1'b1;
          addr <= addr + ADDR_WIDTH'(4);
        end else begin
          x        <= '0;
          y        <= y + 1'b1;
          row_addr <= row_addr + pitch_ext;
          addr     <= row_addr + pitch_ext;
        end
      end

      // A response with nothing outstanding is flagged rather than underflowing.
      case ({issue, mem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if ((mem_rsp_valid && outstanding == '0) || (state == DRAIN && lacc_data_valid))
        err <= 1'b1;

      lacc_drsp_valid <= mem_rsp_valid;
      if (mem_rsp_valid) lacc_drsp_rdata <= mem_rsp_rdata;
    end
  end

endmodule

// File: tb/tb_lacc_data_responder.sv
// Directed bench for lacc_data_responder with a fixed-latency in-order memory model.
module tb_lacc_data_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] row_pitch_i = '0;
  logic [4:0]  buffer_width_i = '0;
  logic [2:0]  buffer_depth_i = '0;
  logic        lacc_data_valid = 1'b0;
  logic        lacc_data_ready;
  logic        lacc_drsp_valid;
  logic [31:0] lacc_drsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        busy, done, err;

  lacc_data_responder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr_i(base_addr_i), .row_pitch_i(row_pitch_i),
    .buffer_width_i(buffer_width_i), .buffer_depth_i(buffer_depth_i),
    .lacc_data_valid(lacc_data_valid), .lacc_data_ready(lacc_data_ready),
    .lacc_drsp_valid(lacc_drsp_valid), .lacc_drsp_rdata(lacc_drsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } ent_t;

  ent_t        mq[$];
  logic [31:0] req_q[$];
  logic [31:0] rsp_q[$];
  bit          rdy_q[$];
  int tests = 0, fails = 0, cyc = 0, lat = 1, issued = 0, total = 0;
  int done_cnt = 0, done_cyc = 0, last_mrsp = 0, lat_bad = 0, tog_base = 0;
  int outst = 0, max_out = 0, first_rsp = -1;
  bit st_drv = 0, tog = 0, stray = 0, prev_mrsp = 0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, then observe and model.
  task automatic cycle();
    ent_t e;
    @(negedge clk);
    cyc++;
    start           = st_drv;
    lacc_data_valid = (issued < total);
    mem_req_ready   = tog ? ((cyc - tog_base) % 2 == 1) : 1'b1;
    mem_rsp_valid   = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      e = mq.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = e.data;
    end else if (stray) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'hDEAD_BEEF;
    end
    #1;
    if (lacc_drsp_valid !== prev_mrsp) lat_bad++;
    prev_mrsp = mem_rsp_valid;
    if (mem_rsp_valid) begin
      outst--;
      last_mrsp = cyc;
      if (first_rsp < 0) first_rsp = cyc - tog_base;
    end
    if (lacc_data_valid && lacc_data_ready) begin
      issued++;
      outst++;
      req_q.push_back(mem_req_addr);
      e.due  = cyc + lat;
      e.data = memdata(mem_req_addr);
      mq.push_back(e);
    end
    if (outst > max_out) max_out = outst;
    rdy_q.push_back(lacc_data_ready);
    if (lacc_drsp_valid) rsp_q.push_back(lacc_drsp_rdata);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic transfer(input int w, input int d, input logic [31:0] base,
                          input logic [15:0] pitch, input int l, input bit t, input string tag);
    logic [31:0] ea;
    int n, k;
    req_q.delete(); rsp_q.delete(); rdy_q.delete();
    done_cnt = 0; issued = 0; total = (w + 1) * (d + 1); outst = 0; max_out = 0;
    first_rsp = -1; lat_bad = 0; lat = l; tog = t;
    buffer_width_i = 5'(w); buffer_depth_i = 3'(d); base_addr_i = base; row_pitch_i = pitch;
    st_drv = 1'b1; tog_base = cyc + 1;
    cycle();
    st_drv = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      cycle();
      n++;
    end
    chk($sformatf("%s_done_seen", tag), 32'(done_cnt), 32'd1);
    chk($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd1);
    cycle();
    chk($sformatf("%s_busy_fell", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_done_once", tag), 32'(done_cnt), 32'd1);
    chk($sformatf("%s_err", tag), 32'(err), 32'd0);
    chk($sformatf("%s_req_count", tag), 32'(req_q.size()), 32'(total));
    chk($sformatf("%s_rsp_count", tag), 32'(rsp_q.size()), 32'(total));
    chk($sformatf("%s_rsp_latency", tag), 32'(lat_bad), 32'd0);
    k = 0;
    for (int yy = 0; yy <= d; yy++) begin
      for (int xx = 0; xx <= w; xx++) begin
        ea = base + 32'(yy) * {16'h0, pitch} + 32'(4 * xx);
        chk($sformatf("%s_addr%0d", tag, k), (k < req_q.size()) ? req_q[k] : 32'hxxxx_xxxx, ea);
        chk($sformatf("%s_data%0d", tag, k), (k < rsp_q.size()) ? rsp_q[k] : 32'hxxxx_xxxx, memdata(ea));
        k++;
      end
    end
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    chk("rst_drsp_valid", 32'(lacc_drsp_valid), 32'd0);
    chk("rst_drsp_rdata", lacc_drsp_rdata, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(lacc_data_ready), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("idle_ready", 32'(lacc_data_ready), 32'd0);

    // 4x2 raster, latency 2
    transfer(3, 1, 32'h1000, 16'h40, 2, 1'b0, "raster");

    // Credit limit with slow memory
    transfer(7, 0, 32'h2000, 16'h0, 10, 1'b0, "credit");
    chk("credit_max_outstanding", 32'(max_out), 32'd4);
    chk("credit_first_rsp", 32'(first_rsp), 32'd11);
    chk("credit_ready_r4", 32'(rdy_q[4]), 32'd1);
    chk("credit_ready_r5", 32'(rdy_q[5]), 32'd0);
    chk("credit_ready_r11", 32'(rdy_q[11]), 32'd0);
    chk("credit_ready_r12", 32'(rdy_q[12]), 32'd1);
    chk("credit_ready_r13", 32'(rdy_q[13]), 32'd1);

    // mem_req_ready toggling
    transfer(3, 0, 32'h2400, 16'h0, 1, 1'b1, "toggle");
    for (int i = 1; i <= 7; i++)
      chk($sformatf("toggle_mirror%0d", i), 32'(rdy_q[i]), 32'(i % 2));
    tog = 1'b0;

    // Single element
    transfer(0, 0, 32'h3000, 16'h10, 1, 1'b0, "single");
    chk("single_done_delay", 32'(done_cyc - last_mrsp), 32'd2);

    // Stray response in IDLE
    stray = 1'b1;
    cycle();
    stray = 1'b0;
    cycle();
    chk("stray_err", 32'(err), 32'd1);
    chk("stray_drsp_valid", 32'(lacc_drsp_valid), 32'd1);
    chk("stray_drsp_rdata", lacc_drsp_rdata, 32'hDEAD_BEEF);
    cycle();
    chk("stray_err_held", 32'(err), 32'd1);
    transfer(1, 1, 32'h5000, 16'h100, 3, 1'b0, "after_stray");

    // Reset with three reads outstanding
    mq.delete(); req_q.delete(); rsp_q.delete();
    total = 8; issued = 0; lat = 10; outst = 0;
    buffer_width_i = 5'd7; buffer_depth_i = 3'd0; base_addr_i = 32'h6000; row_pitch_i = 16'h0;
    st_drv = 1'b1; tog_base = cyc + 1;
    cycle();
    st_drv = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("mid_issued", 32'(issued), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drsp_valid", 32'(lacc_drsp_valid), 32'd0);
    chk("arst_drsp_rdata", lacc_drsp_rdata, 32'd0);
    chk("arst_req_addr", mem_req_addr, 32'd0);
    chk("arst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst_ready", 32'(lacc_data_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    mq.delete();
    total = 0; issued = 0; prev_mrsp = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    transfer(1, 1, 32'h7000, 16'h20, 1, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
